// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage.
//   - datapath width and the shift-amount field position inside the immediate
//   - alu_op encodings
//   - state encoding of the iterative multiply/divide unit
package ex_pkg;

  localparam int WIDTH     = 32;
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_MSB = 10;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;
  localparam logic [3:0] OP_DIVU  = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-step multiply (and optional unsigned divide) unit
// owning the HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start_i; HI/LO stable
// BUSY  | one shift-add / restoring-subtract step per cycle, 32 steps total
//
// Ports:
//   clock, reset_n   clock and async active-low reset
//   start_i          begin an operation (only honoured in IDLE)
//   signed_i         signed multiply (MULT)
//   div_i            unsigned divide (DIVU), used only when EX_DIV_EN is defined
//   a_i, b_i         operands (dividend / divisor for DIVU)
//   busy_o           unit is in BUSY
//   done_o           last step this cycle; HI/LO update at the coming edge
//   hi_o, lo_o       current HI/LO
//
// Macro EX_DIV_EN adds DIVU on the shared iteration register.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e               state_q, state_d;
  logic [4:0]           count_q, count_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, step_next, final_prod;

  assign abs_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: {acc, multiplier}; add multiplicand into acc when the LSB is
  // set, then shift the whole thing right including the carry.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef EX_DIV_EN
  logic                 div_q, div_d;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_next;

  // Restoring divide: {remainder, dividend/quotient}. A zero divisor never
  // borrows, which naturally yields quotient all-ones and remainder = dividend.
  assign div_trial = {1'b0, prod_q[2*WIDTH-1:WIDTH-1]} - {2'b0, opnd_q};
  assign div_next  = div_trial[WIDTH+1] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  assign step_next = div_q ? div_next : mul_next;
`else
  logic unused_div;
  assign unused_div = div_i;
  assign step_next  = mul_next;
`endif

  assign final_prod = neg_q ? -step_next : step_next;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_o  = 1'b0;
`ifdef EX_DIV_EN
    div_d   = div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_BUSY;
          count_d = '0;
          prod_d  = {{WIDTH{1'b0}}, abs_b};
          opnd_d  = abs_a;
          neg_d   = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef EX_DIV_EN
          div_d   = div_i;
          if (div_i) begin
            prod_d = {{WIDTH{1'b0}}, a_i};
            opnd_d = b_i;
            neg_d  = 1'b0;
          end
`endif
        end
      end
      ST_BUSY: begin
        prod_d  = step_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
          hi_d    = final_prod[2*WIDTH-1:WIDTH];
          lo_d    = final_prod[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef EX_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef EX_DIV_EN
      div_q   <= div_d;
`endif
    end
  end

  assign busy_o = (state_q == ST_BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Single-cycle ALU, operand/destination muxes,
// accept logic and EX/MEM output registers; MULT/MULTU (and DIVU) are handed
// to ex_muldiv, which stalls upstream while busy.
//
// Ports: clock, reset_n (async active-low); ID/EX inputs valid_in, alu_op_in,
// alu_src_in, reg_dst_in, reg_write_in, data_a_in, data_b_in, sign_extend_in,
// reg_dest_r_type_in, reg_dest_l_type_in; outputs stall, valid_out,
// alu_result_out, store_data_out, write_reg_out, reg_write_out, zero_out,
// overflow_out.
//
// Macro EX_DIV_EN: op 15 is DIVU; otherwise op 15 is a single-cycle NOP.
module ex_stage
  import ex_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [3:0]       alu_op_in,
  input  logic             alu_src_in,
  input  logic             reg_dst_in,
  input  logic             reg_write_in,
  input  logic [WIDTH-1:0] data_a_in,
  input  logic [WIDTH-1:0] data_b_in,
  input  logic [WIDTH-1:0] sign_extend_in,
  input  logic [4:0]       reg_dest_r_type_in,
  input  logic [4:0]       reg_dest_l_type_in,
  output logic             stall,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [4:0]       write_reg_out,
  output logic             reg_write_out,
  output logic             zero_out,
  output logic             overflow_out
);

  logic [WIDTH-1:0] op_b, sum, diff, hi, lo, alu_res;
  logic [4:0]       shamt;
  logic             ovf_add, ovf_sub, alu_ovf, alu_wr;
  logic             is_iter, accept, md_busy, md_done;

  logic             valid_q, valid_d, rw_q, rw_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d, store_q, store_d;
  logic [4:0]       wreg_q, wreg_d;

  assign op_b  = alu_src_in ? sign_extend_in : data_b_in;
  assign shamt = sign_extend_in[SHAMT_MSB:SHAMT_LSB];
  assign sum   = data_a_in + op_b;
  assign diff  = data_a_in - op_b;

  assign ovf_add = (data_a_in[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != data_a_in[WIDTH-1]);
  assign ovf_sub = (data_a_in[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != data_a_in[WIDTH-1]);

  always_comb begin
    is_iter = (alu_op_in == OP_MULT) || (alu_op_in == OP_MULTU);
`ifdef EX_DIV_EN
    is_iter = is_iter || (alu_op_in == OP_DIVU);
`endif
  end

  assign accept = valid_in && !md_busy;

  ex_muldiv u_muldiv (
    .clock    (clock),
    .reset_n  (reset_n),
    .start_i  (accept && is_iter),
    .signed_i (alu_op_in == OP_MULT),
    .div_i    (alu_op_in == OP_DIVU),
    .a_i      (data_a_in),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_wr  = reg_write_in;
    case (alu_op_in)
      OP_ADD:  begin alu_res = sum;  alu_ovf = ovf_add; end
      OP_SUB:  begin alu_res = diff; alu_ovf = ovf_sub; end
      OP_AND:  alu_res = data_a_in & op_b;
      OP_OR:   alu_res = data_a_in | op_b;
      OP_XOR:  alu_res = data_a_in ^ op_b;
      OP_NOR:  alu_res = ~(data_a_in | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data_a_in) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data_a_in < op_b};
      OP_SLL:  alu_res = op_b << shamt;
      OP_SRL:  alu_res = op_b >> shamt;
      OP_SRA:  alu_res = $signed(op_b) >>> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_wr  = 1'b0;   // iterative ops, or the op-15 NOP
    endcase
    // An overflowing ADD/SUB must not reach the register file.
    if (alu_ovf) alu_wr = 1'b0;
  end

  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    store_d  = store_q;
    wreg_d   = wreg_q;
    rw_d     = rw_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (md_done) begin
      valid_d  = 1'b1;
      result_d = '0;
      rw_d     = 1'b0;
      zero_d   = 1'b1;
      ovf_d    = 1'b0;
    end else if (accept && !is_iter) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      store_d  = data_b_in;
      wreg_d   = reg_dst_in ? reg_dest_r_type_in : reg_dest_l_type_in;
      rw_d     = alu_wr;
      zero_d   = (alu_res == '0);
      ovf_d    = alu_ovf;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      wreg_q   <= '0;
      rw_q     <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      wreg_q   <= wreg_d;
      rw_q     <= rw_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stall          = md_busy;
  assign valid_out      = valid_q;
  assign alu_result_out = result_q;
  assign store_data_out = store_q;
  assign write_reg_out  = wreg_q;
  assign reg_write_out  = rw_q;
  assign zero_out       = zero_q;
  assign overflow_out   = ovf_q;

endmodule
